// File: rtl/ips2l_pcie_dma_pkg.sv
// Shared DMA definitions: CplD header constants, completion status codes,
// CplD generator FSM encoding and the 3DW header packer.
package ips2l_pcie_dma_pkg;

   localparam logic [2:0] CPLD_FMT  = 3'b010;
   localparam logic [4:0] CPLD_TYPE = 5'b01010;

   typedef enum logic [2:0] {
      CPL_SC  = 3'b000,
      CPL_UR  = 3'b001,
      CPL_CRS = 3'b010,
      CPL_CA  = 3'b100
   } cpl_status_e;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_RD_CMD     = 3'd1;
   localparam logic [2:0] ST_WAIT_START = 3'd2;
   localparam logic [2:0] ST_DATA       = 3'd3;
   localparam logic [2:0] ST_FLUSH      = 3'd4;

   typedef struct packed {
      logic [9:0]  length;
      logic [63:0] addr;
      logic [15:0] req_id;
      logic [7:0]  tag;
      logic [2:0]  tc;
      logic [1:0]  attr;
      logic [11:0] byte_cnt;
      logic [6:0]  lower_addr;
      logic [15:0] completer_id;
   } cpld_req_t;

   // Returns {DW2, DW1, DW0}; DW0 lands in bits [31:0] of the first beat.
   function automatic logic [95:0] cpld_hdr_pack(input cpld_req_t r);
      logic [31:0] dw0;
      logic [31:0] dw1;
      logic [31:0] dw2;
      dw0 = {CPLD_FMT, CPLD_TYPE, 1'b0, r.tc, 4'h0, 1'b0, 1'b0, r.attr, 2'b00, r.length};
      dw1 = {r.completer_id, CPL_SC, 1'b0, r.byte_cnt};
      dw2 = {r.req_id, r.tag, 1'b0, r.lower_addr};
      return {dw2, dw1, dw0};
   endfunction

   // Valid DWs left in the residual once the last payload word has gone out.
   function automatic logic [3:0] cpld_flush_keep(input logic [1:0] len_mod);
      logic [3:0] keep;
      case (len_mod)
         2'd0:    keep = 4'b0111;
         2'd2:    keep = 4'b0001;
         2'd3:    keep = 4'b0011;
         default: keep = 4'b1111;
      endcase
      return keep;
   endfunction

endpackage

// File: rtl/ips2l_pcie_dma_cpld_tlp_gen_if.sv
// 128-bit AXI-stream TX channel from the CplD generator to the PCIe core.
interface ips2l_pcie_dma_cpld_tlp_gen_if;
   logic         tvalid;
   logic         tready;
   logic [127:0] tdata;
   logic [3:0]   tkeep;
   logic         tlast;

   modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/ips2l_pcie_dma_cpld_realign.sv
// Shifts 128-bit payload words by three DWs behind the CplD header:
// 96-bit residual register plus registered beat mux.
module ips2l_pcie_dma_cpld_realign (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ld_first,
   input  logic         ld_next,
   input  logic         ld_flush,
   input  logic [95:0]  hdr,
   input  logic [127:0] rd_data,
   output logic [127:0] beat_data
);

   logic [95:0]  residual_reg;
   logic [127:0] beat_reg;
   logic [127:0] beat_next;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         assign beat_next[gi*32 +: 32] = ld_first ? hdr[gi*32 +: 32] : residual_reg[gi*32 +: 32];
      end
   endgenerate

   // Flush beats carry only the residual; the top lane is blanked.
   assign beat_next[127:96] = ld_flush ? 32'd0 : rd_data[31:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         residual_reg <= '0;
         beat_reg     <= '0;
      end else begin
         if (ld_first || ld_next || ld_flush) begin
            beat_reg <= beat_next;
         end
         if (ld_first || ld_next) begin
            residual_reg <= rd_data[127:32];
         end
      end
   end

   assign beat_data = beat_reg;

endmodule

// File: rtl/ips2l_pcie_dma_cpld_tlp_gen.sv
// CplD TLP generator: takes one read request, commands the BAR-RAM read
// controller and streams header plus realigned payload to the core TX port.
module ips2l_pcie_dma_cpld_tlp_gen
   import ips2l_pcie_dma_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_req_valid,
   output logic         o_req_ready,
   input  logic [9:0]   i_req_length,
   input  logic [63:0]  i_req_addr,
   input  logic [15:0]  i_req_id,
   input  logic [7:0]   i_req_tag,
   input  logic [2:0]   i_req_tc,
   input  logic [1:0]   i_req_attr,
   input  logic [11:0]  i_req_byte_cnt,
   input  logic [6:0]   i_req_lower_addr,
   input  logic [15:0]  i_cfg_completer_id,
   output logic         o_rd_en,
   output logic [9:0]   o_rd_length,
   output logic [63:0]  o_rd_addr,
   output logic         o_cpld_tx_hold,
   output logic         o_cpld_tlp_tx,
   input  logic         i_gen_tlp_start,
   input  logic [127:0] i_rd_data,
   input  logic         i_last_data,
   ips2l_pcie_dma_cpld_tlp_gen_if.master axis
);

   logic [2:0]   state_reg;
   logic [2:0]   state_next;
   cpld_req_t    req_reg;
   logic         req_ready_reg;
   logic         rd_en_reg;
   logic         tvalid_reg;
   logic [3:0]   tkeep_reg;
   logic         tlast_reg;
   logic         tlp_tx_reg;
   logic         last_sent_reg;
   logic [127:0] beat_data;

   logic handshake;
   logic beat_acc;
   logic len_mod1;
   logic ld_first;
   logic ld_next;
   logic ld_flush;

   assign handshake = i_req_valid & req_ready_reg;
   assign beat_acc  = tvalid_reg & axis.tready;
   assign len_mod1  = (req_reg.length[1:0] == 2'd1);

   // A word is consumed from the read controller exactly when hold is low.
   assign ld_first = (state_reg == ST_WAIT_START) & i_gen_tlp_start;
   assign ld_next  = (state_reg == ST_DATA) & beat_acc & ~last_sent_reg;
   assign ld_flush = (state_reg == ST_DATA) & beat_acc & last_sent_reg & ~len_mod1;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:       if (handshake) state_next = ST_RD_CMD;
         ST_RD_CMD:     state_next = ST_WAIT_START;
         ST_WAIT_START: if (i_gen_tlp_start) state_next = ST_DATA;
         ST_DATA: begin
            if (beat_acc && last_sent_reg) begin
               state_next = len_mod1 ? ST_IDLE : ST_FLUSH;
            end
         end
         ST_FLUSH:      if (beat_acc) state_next = ST_IDLE;
         default:       state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         req_reg       <= '0;
         req_ready_reg <= 1'b0;
         rd_en_reg     <= 1'b0;
         tvalid_reg    <= 1'b0;
         tkeep_reg     <= 4'd0;
         tlast_reg     <= 1'b0;
         tlp_tx_reg    <= 1'b0;
         last_sent_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         req_ready_reg <= (state_next == ST_IDLE);
         rd_en_reg     <= handshake;
         tlp_tx_reg    <= beat_acc & tlast_reg;
         if (handshake) begin
            req_reg.length       <= i_req_length;
            req_reg.addr         <= i_req_addr;
            req_reg.req_id       <= i_req_id;
            req_reg.tag          <= i_req_tag;
            req_reg.tc           <= i_req_tc;
            req_reg.attr         <= i_req_attr;
            req_reg.byte_cnt     <= i_req_byte_cnt;
            req_reg.lower_addr   <= i_req_lower_addr;
            req_reg.completer_id <= i_cfg_completer_id;
         end
         if (ld_first || ld_next) begin
            tvalid_reg    <= 1'b1;
            tkeep_reg     <= 4'b1111;
            tlast_reg     <= i_last_data & len_mod1;
            last_sent_reg <= i_last_data;
         end else if (ld_flush) begin
            tkeep_reg <= cpld_flush_keep(req_reg.length[1:0]);
            tlast_reg <= 1'b1;
         end else if (beat_acc && tlast_reg) begin
            tvalid_reg <= 1'b0;
            tkeep_reg  <= 4'd0;
            tlast_reg  <= 1'b0;
         end
      end
   end

   ips2l_pcie_dma_cpld_realign u_realign (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_first  (ld_first),
      .ld_next   (ld_next),
      .ld_flush  (ld_flush),
      .hdr       (cpld_hdr_pack(req_reg)),
      .rd_data   (i_rd_data),
      .beat_data (beat_data)
   );

   assign o_req_ready    = req_ready_reg;
   assign o_rd_en        = rd_en_reg;
   assign o_rd_length    = req_reg.length;
   assign o_rd_addr      = req_reg.addr;
   assign o_cpld_tx_hold = (state_reg == ST_DATA) & tvalid_reg & ~axis.tready;
   assign o_cpld_tlp_tx  = tlp_tx_reg;

   assign axis.tvalid = tvalid_reg;
   assign axis.tdata  = beat_data;
   assign axis.tkeep  = tkeep_reg;
   assign axis.tlast  = tlast_reg;

endmodule

// File: doc/ips2l_pcie_dma_cpld_tlp_gen.md
# ips2l_pcie_dma_cpld_tlp_gen

Completion-with-data (CplD) TLP generator for the DMA TX path. Accepts one decoded memory-read request at a time and commands the CplD BAR-RAM read controller to fetch the payload. Packs a 3DW CplD header plus the returned 128-bit payload words into DW-aligned 128-bit AXI-stream beats for the PCIe core TX port. It sits directly downstream of the CplD read controller and drives its hold and TLP-sent inputs.

## Interface
- No parameters; widths are fixed by the read-controller and core TX interfaces.
- clk  in  1  user clock (gen1 62.5 MHz, gen2 125 MHz)
- rst_n  in  1  synchronous, active-low reset
- i_req_valid / o_req_ready  in/out  1  request handshake; transfer when both are high
- i_req_length  in  10  payload length in DW; 0 encodes 1024
- i_req_addr  in  64  BAR-RAM byte address of the payload
- i_req_id  in  16  requester ID
- i_req_tag  in  8  tag
- i_req_tc  in  3  traffic class
- i_req_attr  in  2  attributes
- i_req_byte_cnt  in  12  byte count field
- i_req_lower_addr  in  7  lower address field
- i_cfg_completer_id  in  16  completer ID
- o_rd_en  out  1  one-cycle read command to the read controller
- o_rd_length  out  10  read length in DW
- o_rd_addr  out  64  read address
- o_cpld_tx_hold  out  1  stall for the read controller
- o_cpld_tlp_tx  out  1  one-cycle pulse when the TLP is fully sent
- i_gen_tlp_start  in  1  first payload word is valid on i_rd_data
- i_rd_data  in  128  payload word; DW0 is in [31:0]
- i_last_data  in  1  current payload word is the last
- o_axis_tvalid / i_axis_tready  out/in  1  TX stream handshake
- o_axis_tdata  out  128  TLP beat; DW0 is in [31:0]
- o_axis_tkeep  out  4  per-DW valid flags
- o_axis_tlast  out  1  last beat of the TLP

## Operation
- FSM states: IDLE, RD_CMD, WAIT_START, DATA, FLUSH.
- IDLE:
  - o_req_ready=1.
  - On a request handshake, register all request fields and go to RD_CMD.
- RD_CMD:
  - Drive o_rd_en=1 for exactly one cycle with the registered length and address.
  - Go to WAIT_START.
- WAIT_START:
  - Wait for i_gen_tlp_start, then go to DATA.
  - The first payload word is captured in the cycle i_gen_tlp_start is high.
- Header, packed into DW0..DW2:
  - DW0: fmt=3'b010, type=5'b01010, TC, attr, length.
  - DW1: completer ID, status=3'b000, BCM=0, byte count.
  - DW2: requester ID, tag, 1'b0, lower address.
- Beat 0: {word0[31:0], DW2, DW1, DW0}.
- Beat k≥1: {word_k[31:0], word_{k-1}[127:32]}. The residual word_{k-1}[127:32] is held in a 96-bit register.
- Payload-word advance rule: the read controller advances to the next payload word only in cycles where o_cpld_tx_hold=0. While hold is high, i_rd_data is held stable.
- o_cpld_tx_hold = in DATA, and o_axis_tvalid & ~i_axis_tready. This is combinational.
- Beat count:
  - Payload words W = ceil(len/4).
  - Beats = W if len%4==1; otherwise W+1. The extra beat comes from FLUSH.
- Final payload word:
  - When the beat carrying the word flagged by i_last_data is accepted and len%4==1: that beat has tlast=1, and the FSM returns to IDLE.
  - Otherwise go to FLUSH.
- FLUSH: emit the residual only, with tkeep = {len%4==0: 4'b0111, ==2: 4'b0001, ==3: 4'b0011}, and tlast=1.
- tkeep on non-last beats is 4'b1111.
- o_cpld_tlp_tx pulses for one cycle on acceptance of the tlast beat.

## Timing
- Reset values: o_req_ready=0 during reset, then 1 in IDLE. All other outputs reset to 0. The FSM resets to IDLE.
- Reset mid-TLP drops the TLP silently; no tlast is emitted.
- Request to o_rd_en: 1 cycle after the handshake.
- i_gen_tlp_start to the first o_axis_tvalid: 1 cycle. The beat is registered.
- o_axis_tdata, o_axis_tkeep and o_axis_tlast stay stable while tvalid=1 and tready=0.
- Back-to-back: o_req_ready is reasserted in the cycle after tlast is accepted, giving a minimum 1 idle cycle between TLPs.
- i_gen_tlp_start outside WAIT_START is ignored.
- A length-0 request is handled as 1024 DW: 256 words, 257 beats, final tkeep=4'b0111.

## Structure
- Shared package (ips2l_pcie_dma_pkg) holds:
  - CplD fmt/type constants.
  - Completion status codes.
  - FSM state encoding.
  - A header-pack function.
- One sub-module: ips2l_pcie_dma_cpld_realign, the 96-bit residual register plus beat mux.
- The FSM and handshakes stay in the top.

## Test plan
- len=1, addr=0x40, tag=0x12: 1 beat, tkeep=4'b1111, tlast=1, DW3=word0[31:0]; o_cpld_tlp_tx pulses once.
- len=2: 2 beats; beat1 tkeep=4'b0001 carries word0[63:32].
- len=8: 3 beats; beat2 is a FLUSH with tkeep=4'b0111.
- len=5 with i_axis_tready toggling 1,0,0,1: o_cpld_tx_hold mirrors ~tready, data stays stable, 2 beats.
- len=0 (1024 DW): 257 beats, DW0 length field=0.
- rst_n low during the beat-1 stall: all outputs 0 next cycle, no o_cpld_tlp_tx; a new len=3 request then completes normally.
